// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: CSR map, select encodings,
// trap causes and the WFI sleep states.
package writeback_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_CSR  = 2'b01,
        WB_LOAD = 2'b10,
        WB_PC   = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } ls_size_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } wfi_state_e;

    localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_INSTR_FAULT    = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    localparam logic [31:0] INT_CAUSE_MEI = 32'h8000_000B;

    function automatic logic [31:0] word_align(input logic [31:0] v);
        return {v[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/writeback_load_align.sv
// Picks the addressed byte/half lane out of a raw bus word and extends it.
module writeback_load_align
    import writeback_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        unique case (addr_i)
            2'd0:    byte_lane = data_i[7:0];
            2'd1:    byte_lane = data_i[15:8];
            2'd2:    byte_lane = data_i[23:16];
            default: byte_lane = data_i[31:24];
        endcase
        half_lane = addr_i[1] ? data_i[31:16] : data_i[15:0];

        unique case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: data_o = {{16{signed_i & half_lane[15]}}, half_lane};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Commit stage: register-file write, machine CSRs, traps, mret and WFI sleep.
module writeback
    import writeback_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          HART_ID     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] csr_data_in,
    input  logic [31:0] load_data_in,
    input  logic [1:0]  load_store_size_in,
    input  logic        load_signed_in,
    input  logic [1:0]  write_select_in,
    input  logic [4:0]  rd_address_in,
    input  logic        csr_write_in,
    input  logic [11:0] csr_address_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic        external_interrupt,
    input  logic [11:0] csr_read_address,
    output logic [31:0] csr_read_data,
    output logic        reg_write_enable,
    output logic [4:0]  reg_write_address,
    output logic [31:0] reg_write_data,
    output logic        trap_taken,
    output logic [31:0] trap_address,
    output logic        wfi_stall,
    output logic        retired
);

    logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mscratch_q, mscratch_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    wfi_state_e  state_q, state_d;

    logic        fire, irq_pending, take_trap, do_retire;
    logic [31:0] load_word, wdata;

    writeback_load_align u_align (
        .data_i   (load_data_in),
        .addr_i   (alu_data_in[1:0]),
        .size_i   (load_store_size_in),
        .signed_i (load_signed_in),
        .data_o   (load_word)
    );

    always_comb begin
        fire        = !reset && valid_in && !stall && (state_q == ST_RUN);
        irq_pending = external_interrupt && mie_q && meie_q;
        take_trap   = fire && (exception_in || irq_pending);
        do_retire   = fire && !take_trap;

        unique case (write_select_in)
            WB_ALU:  wdata = alu_data_in;
            WB_CSR:  wdata = csr_data_in;
            WB_LOAD: wdata = load_word;
            default: wdata = next_pc_in;
        endcase

        retired           = do_retire;
        reg_write_enable  = do_retire && (rd_address_in != 5'd0);
        reg_write_address = reg_write_enable ? rd_address_in : 5'd0;
        reg_write_data    = reg_write_enable ? wdata : 32'd0;
        trap_taken        = take_trap || (do_retire && mret_in);
        trap_address      = take_trap ? mtvec_q
                          : trap_taken ? mepc_q : 32'd0;
        wfi_stall         = !reset && (state_q == ST_WAIT);
    end

    always_comb begin
        unique case (csr_read_address)
            CSR_MSTATUS:   csr_read_data = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
            CSR_MIE:       csr_read_data = {20'd0, meie_q, 11'd0};
            CSR_MTVEC:     csr_read_data = mtvec_q;
            CSR_MSCRATCH:  csr_read_data = mscratch_q;
            CSR_MEPC:      csr_read_data = mepc_q;
            CSR_MCAUSE:    csr_read_data = mcause_q;
            CSR_MIP:       csr_read_data = {20'd0, external_interrupt, 11'd0};
            CSR_MCYCLE:    csr_read_data = mcycle_q[31:0];
            CSR_MCYCLEH:   csr_read_data = mcycle_q[63:32];
            CSR_MINSTRET:  csr_read_data = minstret_q[31:0];
            CSR_MINSTRETH: csr_read_data = minstret_q[63:32];
            CSR_MHARTID:   csr_read_data = 32'(HART_ID);
            default:       csr_read_data = 32'd0;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = do_retire ? minstret_q + 64'd1 : minstret_q;
        state_d    = state_q;

        if (take_trap) begin
            mepc_d   = word_align(pc_in);
            mcause_d = exception_in ? {28'd0, ecause_in} : INT_CAUSE_MEI;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (do_retire && mret_in) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        // Explicit counter writes replace the increment, half by half.
        if (do_retire && csr_write_in) begin
            unique case (csr_address_in)
                CSR_MSTATUS: begin
                    mie_d  = alu_data_in[3];
                    mpie_d = alu_data_in[7];
                end
                CSR_MIE:       meie_d     = alu_data_in[11];
                CSR_MTVEC:     mtvec_d    = word_align(alu_data_in);
                CSR_MEPC:      mepc_d     = word_align(alu_data_in);
                CSR_MCAUSE:    mcause_d   = alu_data_in;
                CSR_MSCRATCH:  mscratch_d = alu_data_in;
                CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], alu_data_in};
                CSR_MCYCLEH:   mcycle_d   = {alu_data_in, mcycle_q[31:0]};
                CSR_MINSTRET:  minstret_d = {minstret_q[63:32], alu_data_in};
                CSR_MINSTRETH: minstret_d = {alu_data_in, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (!stall) begin
            unique case (state_q)
                ST_RUN:  if (do_retire && wfi_in) state_d = ST_WAIT;
                default: if (external_interrupt && meie_q) state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mscratch_q <= 32'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
            state_q    <= ST_RUN;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Directed plus random bench for writeback against a behavioural model
// of the machine-mode CSR state, commit rules and WFI sleep.
module tb_writeback;

    localparam logic [31:0] MTV_RST = 32'h0000_0080;
    localparam int          HID     = 3;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
    logic [1:0]  load_store_size_in, write_select_in;
    logic        load_signed_in, csr_write_in, mret_in, wfi_in;
    logic        valid_in, exception_in, external_interrupt;
    logic [4:0]  rd_address_in;
    logic [11:0] csr_address_in, csr_read_address;
    logic [3:0]  ecause_in;
    logic [31:0] csr_read_data, reg_write_data, trap_address;
    logic [4:0]  reg_write_address;
    logic        reg_write_enable, trap_taken, wfi_stall, retired;

    always #5 clk = ~clk;

    writeback #(.MTVEC_RESET(MTV_RST), .HART_ID(HID)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .pc_in(pc_in), .next_pc_in(next_pc_in),
        .alu_data_in(alu_data_in), .csr_data_in(csr_data_in),
        .load_data_in(load_data_in),
        .load_store_size_in(load_store_size_in),
        .load_signed_in(load_signed_in),
        .write_select_in(write_select_in),
        .rd_address_in(rd_address_in),
        .csr_write_in(csr_write_in), .csr_address_in(csr_address_in),
        .mret_in(mret_in), .wfi_in(wfi_in), .valid_in(valid_in),
        .exception_in(exception_in), .ecause_in(ecause_in),
        .external_interrupt(external_interrupt),
        .csr_read_address(csr_read_address),
        .csr_read_data(csr_read_data),
        .reg_write_enable(reg_write_enable),
        .reg_write_address(reg_write_address),
        .reg_write_data(reg_write_data),
        .trap_taken(trap_taken), .trap_address(trap_address),
        .wfi_stall(wfi_stall), .retired(retired)
    );

    bit          m_init, m_mie, m_mpie, m_meie, m_sleep;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
    logic [63:0] m_cyc, m_ret;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load();
        logic [31:0] sh, r;
        sh = load_data_in >> (8 * alu_data_in[1:0]);
        if (load_store_size_in == 2'b00) begin
            r = {24'd0, sh[7:0]};
            if (load_signed_in && sh[7]) r = r | 32'hFFFF_FF00;
        end else if (load_store_size_in == 2'b01) begin
            sh = alu_data_in[1] ? (load_data_in >> 16) : load_data_in;
            r = {16'd0, sh[15:0]};
            if (load_signed_in && sh[15]) r = r | 32'hFFFF_0000;
        end else begin
            r = load_data_in;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_csr(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 0) + (m_mpie ? 32'h80 : 0);
            12'h304: return m_meie ? 32'h800 : 0;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return external_interrupt ? 32'h800 : 0;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ret[31:0];
            12'hB82: return m_ret[63:32];
            12'hF14: return HID;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        bit go, irq, trap, ret, we;
        logic [31:0] e_ta, e_wd, w;
        logic [63:0] c0, r0;
        #1;
        go   = !reset && valid_in && !stall && !m_sleep;
        irq  = external_interrupt && m_mie && m_meie;
        trap = go && (exception_in || irq);
        ret  = go && !trap;
        we   = ret && (rd_address_in != 0);
        e_ta = trap ? m_mtvec : (ret && mret_in) ? m_mepc : 0;
        case (write_select_in)
            2'b00:   e_wd = alu_data_in;
            2'b01:   e_wd = csr_data_in;
            2'b10:   e_wd = ref_load();
            default: e_wd = next_pc_in;
        endcase
        chk("retired", {31'd0, retired}, {31'd0, ret});
        chk("reg_we", {31'd0, reg_write_enable}, {31'd0, we});
        chk("reg_addr", {27'd0, reg_write_address},
            we ? {27'd0, rd_address_in} : 0);
        chk("reg_data", reg_write_data, we ? e_wd : 0);
        chk("trap_taken", {31'd0, trap_taken},
            {31'd0, trap || (ret && mret_in)});
        chk("trap_addr", trap_address, e_ta);
        chk("wfi_stall", {31'd0, wfi_stall}, {31'd0, m_sleep && !reset});
        if (m_init) chk("csr_read", csr_read_data, ref_csr(csr_read_address));
        @(posedge clk);
        if (reset) begin
            m_init = 1; m_mie = 0; m_mpie = 0; m_meie = 0; m_sleep = 0;
            m_mtvec = MTV_RST; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
            m_cyc = 0; m_ret = 0;
        end else begin
            c0 = m_cyc; r0 = m_ret; w = alu_data_in;
            m_cyc = c0 + 1;
            if (!stall && m_sleep && external_interrupt && m_meie) m_sleep = 0;
            if (trap) begin
                m_mepc   = pc_in & ~32'd3;
                m_mcause = exception_in ? {28'd0, ecause_in} : 32'h8000_000B;
                m_mpie   = m_mie;
                m_mie    = 0;
            end
            if (ret) begin
                m_ret = r0 + 1;
                if (mret_in) begin m_mie = m_mpie; m_mpie = 1; end
                if (wfi_in) m_sleep = 1;
                if (csr_write_in)
                    case (csr_address_in)
                        12'h300: begin m_mie = w[3]; m_mpie = w[7]; end
                        12'h304: m_meie = w[11];
                        12'h305: m_mtvec = w & ~32'd3;
                        12'h341: m_mepc = w & ~32'd3;
                        12'h342: m_mcause = w;
                        12'h340: m_mscratch = w;
                        12'hB00: m_cyc = {c0[63:32], w};
                        12'hB80: m_cyc = {w, c0[31:0]};
                        12'hB02: m_ret = {r0[63:32], w};
                        12'hB82: m_ret = {w, r0[31:0]};
                        default: ;
                    endcase
            end
        end
        #1;
    endtask

    task automatic idle();
        stall = 0; valid_in = 0; exception_in = 0; ecause_in = 0;
        external_interrupt = 0; mret_in = 0; wfi_in = 0;
        csr_write_in = 0; csr_address_in = 0; rd_address_in = 0;
        write_select_in = 0; load_store_size_in = 2'b10; load_signed_in = 0;
        pc_in = 32'h40; next_pc_in = 32'h44; alu_data_in = 0;
        csr_data_in = 0; load_data_in = 0;
    endtask

    task automatic csrw(input logic [11:0] a, input logic [31:0] v);
        idle();
        valid_in = 1; csr_write_in = 1; csr_address_in = a; alu_data_in = v;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a,
                          input logic [31:0] exp);
        idle();
        csr_read_address = a;
        #1 chk(tag, csr_read_data, exp);
        tick();
    endtask

    logic [11:0] alist [13] = '{12'h300, 12'h304, 12'h305, 12'h340,
        12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
        12'hF14, 12'h7C0};

    initial begin
        m_init = 0; m_sleep = 0; m_mie = 0; m_meie = 0; m_mpie = 0;
        idle();
        csr_read_address = 12'h305;
        reset = 1;
        tick(); tick();
        reset = 0;
        rd_chk("mtvec_reset", 12'h305, 32'h80);

        csrw(12'h305, 32'h400);
        csrw(12'h300, 32'h8);
        csrw(12'h304, 32'h800);

        idle();
        valid_in = 1; load_data_in = 32'h80FF_7F01; alu_data_in = 3;
        load_store_size_in = 2'b00; load_signed_in = 1;
        write_select_in = 2'b10; rd_address_in = 5;
        #1 chk("lb_data", reg_write_data, 32'hFFFF_FF80);
        chk("lb_we", {31'd0, reg_write_enable}, 32'd1);
        tick();

        idle();
        valid_in = 1; exception_in = 1; ecause_in = 2; pc_in = 32'h100;
        rd_address_in = 7;
        #1 chk("exc_addr", trap_address, 32'h400);
        tick();
        rd_chk("exc_mepc", 12'h341, 32'h100);
        rd_chk("exc_mcause", 12'h342, 32'h2);
        rd_chk("exc_mstatus", 12'h300, 32'h80);

        csrw(12'h341, 32'h204);
        idle();
        valid_in = 1; mret_in = 1;
        #1 chk("mret_addr", trap_address, 32'h204);
        tick();
        rd_chk("mret_mstatus", 12'h300, 32'h88);

        idle();
        valid_in = 1; pc_in = 32'h200; external_interrupt = 1;
        rd_address_in = 3;
        #1 chk("irq_retired", {31'd0, retired}, 32'd0);
        tick();
        rd_chk("irq_mcause", 12'h342, 32'h8000_000B);
        rd_chk("irq_mepc", 12'h341, 32'h200);

        idle();
        valid_in = 1; wfi_in = 1;
        tick();
        idle();
        csr_read_address = 12'hB00;
        for (int i = 0; i < 10; i++) begin
            #1 chk("wfi_sleep", {31'd0, wfi_stall}, 32'd1);
            tick();
        end
        external_interrupt = 1;
        tick();
        external_interrupt = 0;
        #1 chk("wfi_wake", {31'd0, wfi_stall}, 32'd0);
        tick();

        idle();
        valid_in = 1; alu_data_in = 32'h1234;
        #1 chk("x0_we", {31'd0, reg_write_enable}, 32'd0);
        tick();

        idle();
        valid_in = 1; exception_in = 1; ecause_in = 5; stall = 1;
        pc_in = 32'h300;
        #1 chk("stall_trap", {31'd0, trap_taken}, 32'd0);
        tick();
        rd_chk("stall_mcause", 12'h342, 32'h8000_000B);

        csrw(12'h305, 32'h600);
        idle();
        valid_in = 1; wfi_in = 1;
        tick();
        idle();
        #1 chk("wait_before_rst", {31'd0, wfi_stall}, 32'd1);
        reset = 1;
        tick();
        reset = 0;
        rd_chk("rst_mtvec", 12'h305, MTV_RST);

        for (int i = 0; i < 3000; i++) begin
            idle();
            reset = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 9) == 0);
            valid_in = ($urandom_range(0, 3) != 0);
            exception_in = ($urandom_range(0, 15) == 0);
            ecause_in = 4'($urandom_range(0, 11));
            external_interrupt = ($urandom_range(0, 5) == 0);
            mret_in = ($urandom_range(0, 19) == 0);
            wfi_in = ($urandom_range(0, 29) == 0);
            csr_write_in = ($urandom_range(0, 3) == 0);
            csr_address_in = alist[$urandom_range(0, 12)];
            csr_read_address = alist[$urandom_range(0, 12)];
            rd_address_in = 5'($urandom);
            write_select_in = 2'($urandom);
            load_store_size_in = 2'($urandom_range(0, 2));
            load_signed_in = 1'($urandom);
            pc_in = $urandom; next_pc_in = $urandom;
            alu_data_in = $urandom; csr_data_in = $urandom;
            load_data_in = $urandom;
            tick();
        end
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
